register_loader: RTL
====================

Name: register_loader

Overview:
Producer side of the team's loadable-register interface. The block drives the data bus and the load-select strobe of a downstream enable-loaded register. It assembles a WIDTH-bit word from a serial bit stream and loads it into the register with a one-cycle select pulse. It then reads the register output back and checks that the load took, retrying a bounded number of times before flagging an error.

Parameters:
WIDTH, 3, word width; matches the downstream register width
MAX_RETRY, 2, number of extra load attempts after a readback mismatch (0 = no retry)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin collecting a new word
sin  input  1  serial data bit, MSB first
sin_valid  input  1  sin is sampled on cycles where this is high
reg_q  input  WIDTH  readback from the downstream register output
load_data  output  WIDTH  data bus to the downstream register
load_sel  output  1  load strobe to the downstream register; high exactly one cycle per attempt
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a transaction completes (pass or fail)
error  output  1  sticky; set when all attempts mismatch, cleared by the next accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; load_data=0, load_sel=0, busy=0, done=0, error=0.
  - Bit counter and retry counter cleared.
  - A reset mid-transaction abandons it immediately with no done pulse.
  - load_sel is forced low, so no partial load can reach the register.
- All outputs are registered.
- FSM states: IDLE, SHIFT, LOAD, CHECK, DONE.
- IDLE:
  - start=1 -> SHIFT; bit counter=0, retry counter=0, error cleared.
  - sin_valid is ignored in IDLE.
- SHIFT:
  - On each sin_valid=1 cycle, shift register becomes {shift[WIDTH-2:0], sin}; bit counter increments.
  - Cycles with sin_valid=0 hold all state, with no timeout.
  - When the WIDTH-th bit is accepted -> LOAD.
  - load_data is updated with the complete word on that transition, not during shifting.
- LOAD: load_sel=1 for exactly this one cycle, with load_data stable; -> CHECK.
- CHECK:
  - One cycle after the load edge, reg_q is compared against load_data.
  - Match -> DONE, error=0.
  - Mismatch and retry counter < MAX_RETRY -> retry counter+1, back to LOAD (load_sel pulses again).
  - Mismatch and retry counter == MAX_RETRY -> DONE with error=1.
- DONE: done=1 for one cycle; -> IDLE. load_data holds its last value until the next word completes.
- start while busy=1 is ignored and never restarts or queues a transaction.
- start in the same cycle as done: ignored, because the FSM is still in DONE. Software must start in IDLE.
- Latency, start to done with sin_valid continuously high and first-attempt match:
  - 1 cycle to enter SHIFT.
  - WIDTH shift cycles.
  - LOAD, CHECK and DONE, one cycle each.
  - Total WIDTH+4 cycles.
  - Each retry adds 2 cycles.
- Counters:
  - Bit counter width is clog2(WIDTH+1).
  - Retry counter width is clog2(MAX_RETRY+1).
  - Neither counter wraps; both are reset on start.

Decomposition:
- Shared package register_pkg holds:
  - the state enum (IDLE, SHIFT, LOAD, CHECK, DONE);
  - the default WIDTH constant (3), shared with the register block;
  - the default MAX_RETRY constant.
- One sub-module, serial_collector.
  - Contents: the shift register and bit counter.
  - Inputs: clear, sin, sin_valid.
  - Outputs: word and a one-cycle word_ready pulse.
  - register_loader keeps the FSM, the retry logic and the readback compare.

Test Plan:
- Basic load:
  - Stimulus: reset, then start; sin=1,0,1 on three consecutive sin_valid cycles; reg_q modelled by the real register.
  - Response: load_data=3'b101; load_sel high exactly one cycle; done at cycle 7 after start; error=0.
- Gapped input:
  - Stimulus: bits 0,1,1 with sin_valid low for 2 cycles between each bit.
  - Response: load_data=3'b011; done 4 cycles later than the basic case; no early load_sel.
- Stuck register:
  - Stimulus: reg_q held at 3'b000, word 3'b110, MAX_RETRY=2.
  - Response: load_sel pulses 3 times, 2 cycles apart; done, then error=1 sticky.
  - Follow-up: the next start clears error.
- Retry success:
  - Stimulus: reg_q mismatches on attempt 1, matches on attempt 2.
  - Response: 2 load_sel pulses; done with error=0.
- Reset mid-operation:
  - Stimulus: assert reset after 2 bits of word 3'b111.
  - Response: all outputs 0 immediately; no load_sel or done.
  - Follow-up: after release, a new start with word 3'b001 loads 3'b001.
- Ignored start:
  - Stimulus: start pulses during SHIFT and during DONE.
  - Response: the transaction is unaffected; exactly one done; busy drops only after DONE.

Source files
------------

// File: rtl/register_pkg.sv
// register_pkg: definitions shared by the loadable-register producer
// (register_loader) and the downstream register block.
//   - state_e       : register_loader FSM states
//   - REG_WIDTH     : default word width of the loadable register
//   - REG_MAX_RETRY : default number of extra load attempts after a mismatch
package register_pkg;

  localparam int REG_WIDTH     = 3;
  localparam int REG_MAX_RETRY = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/register_loader_serial_collector.sv
// serial_collector: assembles a WIDTH-bit word from an MSB-first bit stream.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   clear             : restart collection (counter and shift register to 0)
//   sin, sin_valid    : serial bit and its qualifier
//   word              : the word including the bit offered this cycle
//   word_ready        : high in the cycle whose accepted bit completes the word
// word/word_ready look one bit ahead so the owner can capture the complete
// word on the very edge that accepts the last bit.
module serial_collector
  import register_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_ready
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] word_s;

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (clear) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (sin_valid && (cnt_r < CNT_W'(WIDTH))) begin
      shift_r <= word_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  generate
    if (WIDTH > 1) begin : g_wide
      assign word_s = {shift_r[WIDTH-2:0], sin};
    end else begin : g_single
      assign word_s = sin;
    end
  endgenerate

  assign word       = word_s;
  assign word_ready = sin_valid && (cnt_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/register_loader.sv
// register_loader: producer side of the loadable-register interface.
// Collects a serial word, loads it into the downstream register with a
// one-cycle load_sel strobe, reads the register back one cycle later and
// retries up to MAX_RETRY extra times before flagging a sticky error.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, accepted only in IDLE
//   sin, sin_valid      : serial data (MSB first) and its qualifier
//   reg_q               : readback of the downstream register
//   load_data, load_sel : data bus and load strobe to the register
//   busy                : high in every state except IDLE
//   done                : one-cycle completion pulse (pass or fail)
//   error               : sticky failure flag, cleared by the next start
// All outputs come straight from flops.
module register_loader
  import register_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter int MAX_RETRY = REG_MAX_RETRY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] load_data,
  output logic             load_sel,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // A zero-retry build still needs a one-bit counter to keep widths legal.
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e             state_r, state_s;
  logic [RETRY_W-1:0] retry_r, retry_s;
  logic [WIDTH-1:0]   load_data_r, load_data_s;
  logic               load_sel_r, load_sel_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               error_r, error_s;
  logic               clear_s;
  logic               shift_valid_s;
  logic [WIDTH-1:0]   word_s;
  logic               word_ready_s;

  // Bits are only collected while the FSM is in SHIFT.
  assign shift_valid_s = sin_valid && (state_r == SHIFT);

  serial_collector #(
    .WIDTH(WIDTH)
  ) u_collector (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .sin        (sin),
    .sin_valid  (shift_valid_s),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that they can be registered and still line up with the state.
  always_comb begin
    state_s     = state_r;
    retry_s     = retry_r;
    load_data_s = load_data_r;
    load_sel_s  = 1'b0;
    done_s      = 1'b0;
    error_s     = error_r;
    clear_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
          retry_s = '0;
          error_s = 1'b0;
          clear_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (word_ready_s) begin
          state_s     = LOAD;
          load_data_s = word_s;
          load_sel_s  = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      LOAD: begin
        state_s = CHECK;
      end
      CHECK: begin
        // reg_q already reflects the load edge that ended the LOAD cycle.
        if (reg_q == load_data_r) begin
          state_s = DONE;
          done_s  = 1'b1;
          error_s = 1'b0;
        end else if (retry_r < RETRY_W'(MAX_RETRY)) begin
          state_s    = LOAD;
          retry_s    = retry_r + RETRY_W'(1);
          load_sel_s = 1'b1;
        end else begin
          state_s = DONE;
          done_s  = 1'b1;
          error_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, retry counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      retry_r     <= '0;
      load_data_r <= '0;
      load_sel_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      retry_r     <= retry_s;
      load_data_r <= load_data_s;
      load_sel_r  <= load_sel_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
    end
  end

  assign load_data = load_data_r;
  assign load_sel  = load_sel_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule
